// File: rtl/alarm_logic_pkg.sv
// Shared widths, classifier class IDs and alarm state encoding for alarm_logic.
// Used by both the RTL and the testbench.
package alarm_logic_pkg;

  localparam int CLASS_W = 2;
  localparam int CONF_W  = 8;

  localparam logic [CLASS_W-1:0] CLASS_HEALTHY   = 2'd0;
  localparam logic [CLASS_W-1:0] CLASS_BEARING   = 2'd1;
  localparam logic [CLASS_W-1:0] CLASS_IMBALANCE = 2'd2;
  localparam logic [CLASS_W-1:0] CLASS_MISALIGN  = 2'd3;

  typedef enum logic {
    ALARM_IDLE   = 1'b0,
    ALARM_RAISED = 1'b1
  } alarm_state_e;

endpackage

// File: rtl/alarm_logic.sv
// Qualifies classifier results against a confidence threshold, counts consecutive confident faults
// and raises a level alarm plus one-cycle irq. Optional: ALARM_CLEAR_IRQ_EN also pulses irq on clear.
module alarm_logic
  import alarm_logic_pkg::*;
#(
  parameter int CLASS_W = alarm_logic_pkg::CLASS_W,
  parameter int CONF_W  = alarm_logic_pkg::CONF_W,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               classification_done,
  input  logic [CLASS_W-1:0] class_id,
  input  logic [CONF_W-1:0]  confidence,
  input  logic [CONF_W-1:0]  alarm_threshold,
  input  logic [CNT_W-1:0]   fault_count_cfg,
  output logic               alarm_active,
  output logic               alarm_irq,
  output logic [CLASS_W-1:0] last_fault_class
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  alarm_state_e       state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CLASS_W-1:0] lfc_reg, lfc_next;
  logic               irq_reg, irq_next;

  logic               confident;
  logic               is_fault;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   target;

  assign confident = classification_done && (confidence >= alarm_threshold);
  assign is_fault  = (class_id != CLASS_W'(CLASS_HEALTHY));
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
  // A programmed count of zero would otherwise mean "alarm with no faults".
  assign target    = (fault_count_cfg == '0) ? CNT_W'(1) : fault_count_cfg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ALARM_IDLE;
      cnt_reg   <= '0;
      lfc_reg   <= '0;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lfc_reg   <= lfc_next;
      irq_reg   <= irq_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lfc_next   = lfc_reg;
    irq_next   = 1'b0;

    if (confident) begin
      if (is_fault) begin
        cnt_next = cnt_inc;
        lfc_next = class_id;
        if (cnt_inc >= target) begin
          state_next = ALARM_RAISED;
        end
      end else begin
        cnt_next   = '0;
        state_next = ALARM_IDLE;
      end
    end

    if ((state_reg == ALARM_IDLE) && (state_next == ALARM_RAISED)) begin
      irq_next = 1'b1;
    end
`ifdef ALARM_CLEAR_IRQ_EN
    if ((state_reg == ALARM_RAISED) && (state_next == ALARM_IDLE)) begin
      irq_next = 1'b1;
    end
`endif
  end

  assign alarm_active     = (state_reg == ALARM_RAISED);
  assign alarm_irq        = irq_reg;
  assign last_fault_class = lfc_reg;

endmodule

// File: tb/tb_alarm_logic.sv
// Directed testbench for alarm_logic: a reference model pushes expected outputs per cycle into a
// scoreboard queue, which is popped and compared one cycle later.
module tb_alarm_logic;
  import alarm_logic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        classification_done;
  logic [1:0]  class_id;
  logic [7:0]  confidence;
  logic [7:0]  alarm_threshold;
  logic [3:0]  fault_count_cfg;
  logic        alarm_active;
  logic        alarm_irq;
  logic [1:0]  last_fault_class;

  typedef struct packed {
    logic       alarm;
    logic       irq;
    logic [1:0] lfc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state
  int   m_cnt   = 0;
  logic m_alarm = 1'b0;
  logic [1:0] m_lfc = 2'd0;

  alarm_logic dut (
    .clk                 (clk),
    .rst                 (rst),
    .classification_done (classification_done),
    .class_id            (class_id),
    .confidence          (confidence),
    .alarm_threshold     (alarm_threshold),
    .fault_count_cfg     (fault_count_cfg),
    .alarm_active        (alarm_active),
    .alarm_irq           (alarm_irq),
    .last_fault_class    (last_fault_class)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Model one clock edge given the inputs currently driven; push expected outputs.
  task automatic model_push(input logic done);
    exp_t e;
    int   tgt;
    logic irq;
    irq = 1'b0;
    if (done && (confidence >= alarm_threshold)) begin
      if (class_id != CLASS_HEALTHY) begin
        if (m_cnt < 15) m_cnt++;
        m_lfc = class_id;
        tgt = (fault_count_cfg == 0) ? 1 : int'(fault_count_cfg);
        if (m_cnt >= tgt && !m_alarm) begin
          m_alarm = 1'b1;
          irq     = 1'b1;
        end
      end else begin
`ifdef ALARM_CLEAR_IRQ_EN
        if (m_alarm) irq = 1'b1;
`endif
        m_alarm = 1'b0;
        m_cnt   = 0;
      end
    end
    e.alarm = m_alarm;
    e.irq   = irq;
    e.lfc   = m_lfc;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".alarm"}, 8'(alarm_active), 8'(e.alarm));
    chk({tag, ".irq"}, 8'(alarm_irq), 8'(e.irq));
    chk({tag, ".lfc"}, 8'(last_fault_class), 8'(e.lfc));
  endtask

  task automatic send(input logic [1:0] cls, input logic [7:0] conf, input string tag);
    @(negedge clk);
    classification_done = 1'b1;
    class_id   = cls;
    confidence = conf;
    model_push(1'b1);
    @(posedge clk);
    #1;
    $display("txn %s: class=%0d conf=%0d -> alarm=%0d irq=%0d lfc=%0d",
             tag, cls, conf, alarm_active, alarm_irq, last_fault_class);
    pop_check(tag);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    classification_done = 1'b0;
    model_push(1'b0);
    @(posedge clk);
    #1;
    $display("txn %s: idle -> alarm=%0d irq=%0d lfc=%0d",
             tag, alarm_active, alarm_irq, last_fault_class);
    pop_check(tag);
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_alarm = 1'b0;
    m_lfc   = 2'd0;
  endtask

  initial begin
    rst = 1'b1;
    classification_done = 1'b0;
    class_id        = 2'd0;
    confidence      = 8'd0;
    alarm_threshold = 8'd100;
    fault_count_cfg = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.alarm", 8'(alarm_active), 8'd0);
    chk("reset.irq", 8'(alarm_irq), 8'd0);
    chk("reset.lfc", 8'(last_fault_class), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // healthy stream never alarms
    for (int i = 0; i < 10; i++) send(CLASS_HEALTHY, 8'd200, "healthy");

    // third consecutive fault raises alarm, fourth does not re-pulse
    send(CLASS_BEARING, 8'd200, "fault1");
    send(CLASS_BEARING, 8'd200, "fault2");
    send(CLASS_BEARING, 8'd200, "fault3_raise");
    send(CLASS_BEARING, 8'd200, "fault4_hold");
    idle("post_raise_idle");

    // confident healthy clears; lfc held
    send(CLASS_HEALTHY, 8'd200, "clear");
    idle("post_clear_idle");

    // low-confidence faults ignored
    for (int i = 0; i < 10; i++) send(CLASS_IMBALANCE, 8'd50, "lowconf");

    // equality qualifies; mixed classes counted together
    send(CLASS_IMBALANCE, 8'd100, "eq_thr1");
    send(CLASS_BEARING, 8'd99, "below_thr");
    send(CLASS_MISALIGN, 8'd100, "eq_thr2");
    send(CLASS_IMBALANCE, 8'd255, "eq_thr3_raise");
    send(CLASS_HEALTHY, 8'd99, "lowconf_healthy");
    send(CLASS_HEALTHY, 8'd100, "clear2");

    // healthy between faults restarts the count
    send(CLASS_MISALIGN, 8'd200, "m1");
    send(CLASS_MISALIGN, 8'd200, "m2");
    send(CLASS_HEALTHY, 8'd200, "m_reset");
    send(CLASS_MISALIGN, 8'd200, "m3");
    send(CLASS_MISALIGN, 8'd200, "m4");

    // lowering cfg alone must not raise the alarm
    fault_count_cfg = 4'd1;
    idle("cfg_lower_idle1");
    idle("cfg_lower_idle2");
    send(CLASS_BEARING, 8'd200, "cfg1_raise");
    send(CLASS_HEALTHY, 8'd200, "clear3");

    // cfg 0 acts as 1
    fault_count_cfg = 4'd0;
    send(CLASS_BEARING, 8'd200, "cfg0_raise");
    send(CLASS_HEALTHY, 8'd200, "clear4");

    // saturation: many faults with high target
    fault_count_cfg = 4'd15;
    for (int i = 0; i < 20; i++) send(CLASS_IMBALANCE, 8'd200, "sat");
    send(CLASS_HEALTHY, 8'd200, "clear5");

    // async reset mid-sequence after two faults
    fault_count_cfg = 4'd3;
    send(CLASS_BEARING, 8'd200, "r1");
    send(CLASS_MISALIGN, 8'd200, "r2");
    @(negedge clk);
    classification_done = 1'b1;
    class_id   = CLASS_BEARING;
    confidence = 8'd200;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.alarm", 8'(alarm_active), 8'd0);
    chk("async_rst.irq", 8'(alarm_irq), 8'd0);
    chk("async_rst.lfc", 8'(last_fault_class), 8'd0);
    model_reset();
    // strobe held during reset edge is discarded
    @(posedge clk);
    #1;
    chk("rst_strobe.lfc", 8'(last_fault_class), 8'd0);
    chk("rst_strobe.alarm", 8'(alarm_active), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    classification_done = 1'b0;

    send(CLASS_BEARING, 8'd200, "after_rst1");
    send(CLASS_BEARING, 8'd200, "after_rst2");
    send(CLASS_BEARING, 8'd200, "after_rst3_raise");
    idle("final_idle");

    checks++;
    assert (sb_q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
